fresh_prng_source: RTL and testbench

- Producer of the fresh randomness bus consumed by the second-order HPC2 masked NLFSR core.
- Per accepted transfer it delivers one 96-bit Fresh word, i.e. 32 gadgets x 3 bits.
- Internal xorshift128 generator; it outputs three unrolled steps per cycle.
- Seeded over a 32-bit handshake port. It sits between the TRNG/seed interface and the masked TinyJAMBU datapath.

---
 rtl/fresh_prng_source_if.sv | 21 ++
 rtl/fresh_prng_source.sv | 199 +++++++++++++++++++
 tb/tb_fresh_prng_source.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fresh_prng_source_if.sv
// rtl/fresh_prng_source_if.sv - seed input and Fresh output handshake bundle for fresh_prng_source
interface fresh_prng_source_if;
  logic [31:0] seed_in;
  logic        seed_valid;
  logic        seed_ready;
  logic [95:0] Fresh;
  logic        fresh_valid;
  logic        fresh_ready;
  logic        busy;
  logic        health_alarm;

  modport master (
    input  seed_in, seed_valid, fresh_ready,
    output seed_ready, Fresh, fresh_valid, busy, health_alarm
  );

  modport slave (
    output seed_in, seed_valid, fresh_ready,
    input  seed_ready, Fresh, fresh_valid, busy, health_alarm
  );
endinterface

// File: rtl/fresh_prng_source.sv
// rtl/fresh_prng_source.sv - xorshift128 fresh randomness source, 96 bits per transfer (optional FRESH_HEALTH_EN)
module fresh_prng_source #(
  parameter int unsigned WARMUP_STEPS = 16,
  parameter int unsigned SEED_WORDS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fresh_prng_source_if.master  bus
);

  if (SEED_WORDS != 4 || WARMUP_STEPS > 255) begin : g_param_check
    $error("fresh_prng_source: SEED_WORDS must be 4 and WARMUP_STEPS must be 0..255");
  end

  localparam logic [7:0] WARM = WARMUP_STEPS[7:0];

  typedef enum logic [2:0] {
    ST_UNSEEDED,
    ST_SEED,
    ST_WARMUP,
    ST_RUN,
    ST_RUN_HALT
  } state_t;

  // One xorshift128 step: new w from the oldest word x and newest word w.
  function automatic logic [31:0] xs_out(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] t;
    t = a ^ (a << 11);
    return w ^ (w >> 19) ^ t ^ (t >> 8);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] x_q, y_q, z_q, w_q;
  logic [31:0] x_d, y_d, z_d, w_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fresh_valid_q, fresh_valid_d;
  logic        seed_ready_q, seed_ready_d;
  logic        busy_q, busy_d;

  logic        seed_acc, fresh_acc, reseed;
  logic [31:0] seed_w, chain_w, o1, o2, o3;

`ifdef FRESH_HEALTH_EN
  logic [95:0] prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d;
  logic        alarm_q, alarm_d;
`endif

  // Next-state logic. After three chained steps the state is {w0, o1, o2, o3},
  // so y/z/w already hold the three outputs and double as the Fresh register.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    w_d     = w_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef FRESH_HEALTH_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    alarm_d    = alarm_q;
`endif

    seed_acc  = bus.seed_valid & seed_ready_q;
    fresh_acc = fresh_valid_q & bus.fresh_ready;
    reseed    = seed_acc && (state_q == ST_UNSEEDED || state_q == ST_RUN ||
                             state_q == ST_RUN_HALT);

    // The all-zero state is a fixed point of xorshift, so the last seed word is patched.
    seed_w  = ((x_q | y_q | z_q | bus.seed_in) == 32'd0) ? 32'd1 : bus.seed_in;
    chain_w = (state_q == ST_SEED) ? seed_w : w_q;
    o1      = xs_out(x_q, chain_w);
    o2      = xs_out(y_q, o1);
    o3      = xs_out(z_q, o2);

    if (reseed) begin
      x_d     = bus.seed_in;
      idx_d   = 2'd1;
      state_d = ST_SEED;
`ifdef FRESH_HEALTH_EN
      prev_vld_d = 1'b0;
      alarm_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_SEED: begin
          if (seed_acc) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd1: y_d = bus.seed_in;
              2'd2: z_d = bus.seed_in;
              default: begin
                // Prime the generator on the final word so the first Fresh is ready at once.
                x_d = chain_w;
                y_d = o1;
                z_d = o2;
                w_d = o3;
                if (WARM == 8'd0) begin
                  state_d = ST_RUN;
                end else begin
                  state_d = ST_WARMUP;
                  cnt_d   = WARM;
                end
              end
            endcase
          end
        end
        ST_WARMUP: begin
          x_d   = chain_w;
          y_d   = o1;
          z_d   = o2;
          w_d   = o3;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fresh_acc) begin
`ifdef FRESH_HEALTH_EN
            if (prev_vld_q && ({w_q, z_q, y_q} == prev_q)) begin
              alarm_d = 1'b1;
              state_d = ST_RUN_HALT;
            end else begin
              prev_d     = {w_q, z_q, y_q};
              prev_vld_d = 1'b1;
              x_d = chain_w;
              y_d = o1;
              z_d = o2;
              w_d = o3;
            end
`else
            x_d = chain_w;
            y_d = o1;
            z_d = o2;
            w_d = o3;
`endif
          end
        end
        default: ;
      endcase
    end

    fresh_valid_d = (state_d == ST_RUN);
    seed_ready_d  = (state_d != ST_WARMUP);
    busy_d        = (state_d == ST_SEED) || (state_d == ST_WARMUP);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_UNSEEDED;
      x_q           <= 32'd0;
      y_q           <= 32'd0;
      z_q           <= 32'd0;
      w_q           <= 32'd0;
      idx_q         <= 2'd0;
      cnt_q         <= 8'd0;
      fresh_valid_q <= 1'b0;
      seed_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      w_q           <= w_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      fresh_valid_q <= fresh_valid_d;
      seed_ready_q  <= seed_ready_d;
      busy_q        <= busy_d;
    end
  end

`ifdef FRESH_HEALTH_EN
  // Repetition monitor state; the alarm is sticky until reset or reseed.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= 96'd0;
      prev_vld_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      alarm_q    <= alarm_d;
    end
  end
  assign bus.health_alarm = alarm_q;
`else
  assign bus.health_alarm = 1'b0;
`endif

  assign bus.Fresh       = fresh_valid_q ? {w_q, z_q, y_q} : 96'd0;
  assign bus.fresh_valid = fresh_valid_q;
  assign bus.seed_ready  = seed_ready_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fresh_prng_source.sv
// tb/tb_fresh_prng_source.sv - self-checking bench for fresh_prng_source against an xorshift128 model
module tb_fresh_prng_source;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  fresh_prng_source_if ifa ();
  fresh_prng_source_if ifb ();

  fresh_prng_source #(.WARMUP_STEPS(0),  .SEED_WORDS(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fresh_prng_source #(.WARMUP_STEPS(16), .SEED_WORDS(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Reference generator: plain xorshift128, one step at a time.
  logic [31:0] mx, my, mz, mw;

  task automatic m_seed(input logic [127:0] s);
    mx = s[31:0];
    my = s[63:32];
    mz = s[95:64];
    mw = s[127:96];
    if (s == 128'd0) mw = 32'd1;
  endtask

  task automatic m_step(output logic [31:0] o);
    logic [31:0] t;
    t  = mx ^ (mx << 11);
    o  = mw ^ (mw >> 19) ^ t ^ (t >> 8);
    mx = my;
    my = mz;
    mz = mw;
    mw = o;
  endtask

  task automatic m_word(output logic [95:0] e);
    logic [31:0] a, b, c;
    m_step(a);
    m_step(b);
    m_step(c);
    e = {c, b, a};
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_words(input bit sel, input logic [127:0] s, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int waitc = 0;
      while (!(sel ? ifb.seed_ready : ifa.seed_ready) && waitc < 100) begin
        tick();
        waitc++;
      end
      chk("seed_ready_wait", 96'(waitc < 100), 96'd1);
      if (sel) begin
        ifb.seed_in = s[32*i +: 32];
        ifb.seed_valid = 1'b1;
      end else begin
        ifa.seed_in = s[32*i +: 32];
        ifa.seed_valid = 1'b1;
      end
      tick();
      ifa.seed_valid = 1'b0;
      ifb.seed_valid = 1'b0;
    end
  endtask

  task automatic stream_a(input int n, input bit rnd_stall, input bit nonzero);
    logic [95:0] e;
    int stall;
    for (int k = 0; k < n; k++) begin
      m_word(e);
      stall = 0;
      if (rnd_stall && $urandom_range(0, 3) == 0) stall = $urandom_range(1, 3);
      for (int j = 0; j < stall; j++) begin
        ifa.fresh_ready = 1'b0;
        tick();
        chk("hold_valid", 96'(ifa.fresh_valid), 96'd1);
        chk("hold_data", ifa.Fresh, e);
      end
      chk("stream_valid", 96'(ifa.fresh_valid), 96'd1);
      chk("stream_word", ifa.Fresh, e);
      if (nonzero) chk("nonzero_word", 96'(ifa.Fresh != 96'd0), 96'd1);
      ifa.fresh_ready = 1'b1;
      tick();
      ifa.fresh_ready = 1'b0;
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_valid"}, 96'(ifa.fresh_valid), 96'd0);
    chk({tag, "_seed_ready"}, 96'(ifa.seed_ready), 96'd1);
    chk({tag, "_busy"}, 96'(ifa.busy), 96'd0);
    chk({tag, "_fresh"}, ifa.Fresh, 96'd0);
    chk({tag, "_alarm"}, 96'(ifa.health_alarm), 96'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] golden, ns, ns2, zero;
    logic [95:0]  e;
    logic [31:0]  dump;
    logic [95:0]  held;
    int           cyc;

    golden = {32'd88675123, 32'd521288629, 32'd362436069, 32'd123456789};
    zero   = 128'd0;
    ifa.seed_in = 32'd0; ifa.seed_valid = 1'b0; ifa.fresh_ready = 1'b0;
    ifb.seed_in = 32'd0; ifb.seed_valid = 1'b0; ifb.fresh_ready = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_a("reset_a");
    chk("reset_b_valid", 96'(ifb.fresh_valid), 96'd0);
    chk("reset_b_busy", 96'(ifb.busy), 96'd0);
    chk("reset_b_seed_ready", 96'(ifb.seed_ready), 96'd1);

    // Golden seed, no warm-up: first word known from the reference C generator.
    seed_words(1'b0, golden, 0, 4);
    chk("first_valid", 96'(ifa.fresh_valid), 96'd1);
    chk("first_busy", 96'(ifa.busy), 96'd0);
    chk("first_lo", 96'(ifa.Fresh[31:0]), 96'd3701687786);
    chk("first_mid", 96'(ifa.Fresh[63:32]), 96'd458299110);
    chk("first_hi", 96'(ifa.Fresh[95:64]), 96'd2500872618);
    m_seed(golden);
    stream_a(1000, 1'b1, 1'b0);

    // Long stall mid-stream.
    m_word(e);
    held = ifa.Fresh;
    chk("stall_entry", held, e);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("stall10_valid", 96'(ifa.fresh_valid), 96'd1);
      chk("stall10_data", ifa.Fresh, e);
    end
    ifa.fresh_ready = 1'b1;
    tick();
    ifa.fresh_ready = 1'b0;
    stream_a(5, 1'b0, 1'b0);

    // Reseed colliding with an accept: reseed wins.
    ns = {$urandom(), $urandom(), $urandom(), $urandom()};
    ifa.seed_in = ns[31:0];
    ifa.seed_valid = 1'b1;
    ifa.fresh_ready = 1'b1;
    tick();
    ifa.seed_valid = 1'b0;
    ifa.fresh_ready = 1'b0;
    chk("reseed_valid_drop", 96'(ifa.fresh_valid), 96'd0);
    chk("reseed_busy", 96'(ifa.busy), 96'd1);
    chk("reseed_fresh_zero", ifa.Fresh, 96'd0);
    seed_words(1'b0, ns, 1, 3);
    m_seed(ns);
    stream_a(30, 1'b1, 1'b0);

    // Reset in the middle of seeding.
    ns2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    seed_words(1'b0, ns2, 0, 2);
    chk("partial_seed_busy", 96'(ifa.busy), 96'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a("midseed_reset");
    seed_words(1'b0, golden, 0, 4);
    chk("reseed_golden_lo", 96'(ifa.Fresh[31:0]), 96'd3701687786);
    m_seed(golden);
    stream_a(10, 1'b0, 1'b0);

    // All-zero seed is patched to {0,0,0,1}.
    ifa.seed_in = 32'd0;
    ifa.seed_valid = 1'b1;
    tick();
    ifa.seed_valid = 1'b0;
    seed_words(1'b0, zero, 1, 3);
    m_seed(zero);
    stream_a(100, 1'b1, 1'b1);

    // Warm-up instance: valid rises 16 cycles after the last seed handshake.
    seed_words(1'b1, golden, 0, 4);
    chk("warm_valid_low", 96'(ifb.fresh_valid), 96'd0);
    chk("warm_busy", 96'(ifb.busy), 96'd1);
    chk("warm_seed_ready", 96'(ifb.seed_ready), 96'd0);
    cyc = 0;
    while (!ifb.fresh_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("warm_latency", 96'(cyc), 96'd16);
    chk("warm_busy_done", 96'(ifb.busy), 96'd0);
    m_seed(golden);
    for (int k = 0; k < 48; k++) m_step(dump);
    m_word(e);
    chk("warm_first_word", ifb.Fresh, e);
    ifb.fresh_ready = 1'b1;
    tick();
    ifb.fresh_ready = 1'b0;
    m_word(e);
    chk("warm_second_word", ifb.Fresh, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
